// File: rtl/conv_norm_buffer_if.sv
// Handshake bundle between the convolution producer, conv_norm_buffer and the
// pixel consumer. master = environment (producer + consumer), slave = buffer.
interface conv_norm_buffer_if;
    logic        conv_valid;
    logic [15:0] conv_data;
    logic        in_ready;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        frame_done;
    logic        overflow;

    modport master (
        output conv_valid, conv_data, pix_ready,
        input  in_ready, pix_valid, pix_data, frame_done, overflow
    );

    modport slave (
        input  conv_valid, conv_data, pix_ready,
        output in_ready, pix_valid, pix_data, frame_done, overflow
    );
endinterface

// File: rtl/conv_norm_buffer.sv
// conv_norm_buffer: normalises signed 16-bit convolution results to 8-bit
// pixels (arithmetic shift + clamp to 0..255), buffers them in a DEPTH-entry
// FIFO drained over valid/ready, counts FRAME_LEN results per frame and pulses
// frame_done once the closed frame has fully left the FIFO. A result offered
// while in_ready is low is dropped and sets the sticky overflow flag.
// Optional feature macro: CONV_NORM_ROUND_EN selects round-to-nearest instead
// of truncation before the clamp.
module conv_norm_buffer #(
    parameter int unsigned SHIFT     = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FRAME_LEN = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_norm_buffer_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned CW = $clog2(FRAME_LEN + 1);

`ifdef CONV_NORM_ROUND_EN
    // One guard bit so adding the rounding constant never wraps at 0x7FFF.
    localparam int unsigned          NW  = 17;
    localparam logic signed [NW-1:0] RND = NW'(1 << (SHIFT - 1));
`else
    localparam int unsigned          NW  = 16;
    localparam logic signed [NW-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]        occ_q, occ_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           mem_q [DEPTH];

    logic                 full;
    logic                 empty;
    logic                 in_ready;
    logic                 accept;
    logic                 pop;
    logic                 frame_done;
    logic signed [NW-1:0] ext;
    logic signed [NW-1:0] scaled;
    logic [7:0]           norm;

    assign full     = (occ_q == OW'(DEPTH));
    assign empty    = (occ_q == '0);
    assign in_ready = !full && (state_q != S_DRAIN);
    assign accept   = bus.conv_valid && in_ready;
    assign pop      = !empty && bus.pix_ready;

    assign bus.in_ready   = in_ready;
    assign bus.pix_valid  = !empty;
    // Gate the head so pix_data reads 0x00 after reset with unreset storage.
    assign bus.pix_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.frame_done = frame_done;
    assign bus.overflow   = ovf_q;

    // Normalise: sign-extend, optional rounding offset, arithmetic shift, clamp.
    always_comb begin
        ext    = NW'($signed(bus.conv_data));
        scaled = (ext + RND) >>> SHIFT;
        if (scaled[NW-1]) begin
            norm = 8'h00;
        end else if (|scaled[NW-2:8]) begin
            norm = 8'hFF;
        end else begin
            norm = scaled[7:0];
        end
    end

    // Next state for FSM, FIFO pointers/occupancy, frame count and overflow.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_done = 1'b0;
        ovf_d      = ovf_q | (bus.conv_valid & ~in_ready);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;

        if (accept) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    cnt_d   = CW'(1);
                    state_d = (FRAME_LEN == 1) ? S_DRAIN : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == CW'(FRAME_LEN)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (empty) begin
                    frame_done = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= norm;
        end
    end

endmodule

// File: tb/tb_conv_norm_buffer.sv
// Directed self-checking bench for conv_norm_buffer (SHIFT=4, DEPTH=4,
// FRAME_LEN=9): a normalisation vector table plus hand sequences for full
// frames, backpressure/overflow, simultaneous push/pop, reset mid-frame and
// DRAIN gating.
module tb_conv_norm_buffer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   fd_count;

    conv_norm_buffer_if bus ();

    conv_norm_buffer #(
        .SHIFT     (4),
        .DEPTH     (4),
        .FRAME_LEN (9)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_done pulses (sampled at the edge that ends each cycle).
    always @(posedge clk) begin
        if (bus.frame_done === 1'b1) fd_count++;
    end

    typedef struct {
        logic [15:0] din;
        logic [7:0]  exp;
    } vec_t;

`ifdef CONV_NORM_ROUND_EN
    localparam logic [7:0] EXP_0018 = 8'h02;
    localparam logic [7:0] EXP_000F = 8'h01;
`else
    localparam logic [7:0] EXP_0018 = 8'h01;
    localparam logic [7:0] EXP_000F = 8'h00;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.conv_valid = 1'b0;
        bus.pix_ready  = 1'b0;
        #1;
        check("rst_in_ready",   bus.in_ready,   1'b1);
        check("rst_pix_valid",  bus.pix_valid,  1'b0);
        check("rst_pix_data",   bus.pix_data,   8'h00);
        check("rst_frame_done", bus.frame_done, 1'b0);
        check("rst_overflow",   bus.overflow,   1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Nine back-to-back results with pix_ready high; optionally keep
    // conv_valid asserted through DRAIN to exercise the input gating.
    task automatic full_frame(input logic [7:0] base, input logic hold);
        int         fd0;
        logic [7:0] p;
        fd0 = fd_count;
        bus.pix_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            p = base + 8'(k);
            bus.conv_valid = 1'b1;
            bus.conv_data  = {4'h0, p, 4'h0};
            @(negedge clk);
            check("ff_pix_valid", bus.pix_valid, 1'b1);
            check("ff_pix_data",  bus.pix_data,  p);
            check("ff_in_ready",  bus.in_ready,  (k < 9) ? 1'b1 : 1'b0);
            check("ff_fd_early",  bus.frame_done, 1'b0);
        end
        bus.conv_valid = hold;
        bus.conv_data  = 16'h0550;
        @(negedge clk);
        check("ff_frame_done", bus.frame_done, 1'b1);
        check("ff_drain_pv",   bus.pix_valid,  1'b0);
        check("ff_drain_rdy",  bus.in_ready,   1'b0);
        check("ff_drain_ovf",  bus.overflow,   hold);
        @(negedge clk);
        bus.conv_valid = 1'b0;
        check("ff_fd_single",  bus.frame_done, 1'b0);
        check("ff_idle_rdy",   bus.in_ready,   1'b1);
        check("ff_idle_pv",    bus.pix_valid,  1'b0);
        repeat (3) @(negedge clk);
        check("ff_no_extra_pix", bus.pix_valid, 1'b0);
        check("ff_fd_count",     fd_count - fd0, 1);
        check("ff_ovf_final",    bus.overflow, hold);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[10];
        logic [7:0]  bp_exp[4];
        logic [7:0]  pp[8];
        int          fd0;

        checks = 0;
        errors = 0;
        fd_count = 0;
        rst_n = 1'b1;
        bus.conv_valid = 1'b0;
        bus.conv_data  = '0;
        bus.pix_ready  = 1'b0;

        vecs[0] = '{16'h0123, 8'h12};
        vecs[1] = '{16'h0FFF, 8'hFF};
        vecs[2] = '{16'h1000, 8'hFF};
        vecs[3] = '{16'hFFF0, 8'h00};
        vecs[4] = '{16'h0018, EXP_0018};
        vecs[5] = '{16'h7FFF, 8'hFF};
        vecs[6] = '{16'h8000, 8'h00};
        vecs[7] = '{16'h000F, EXP_000F};
        vecs[8] = '{16'h0FF8, 8'hFF};
        vecs[9] = '{16'h0100, 8'h10};

        do_reset();

        // Normalisation table: one result at a time, popped immediately.
        bus.pix_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            for (int n = 0; n < 20 && bus.in_ready !== 1'b1; n++) @(negedge clk);
            check("tbl_ready_wait", bus.in_ready, 1'b1);
            bus.conv_valid = 1'b1;
            bus.conv_data  = vecs[i].din;
            @(negedge clk);
            bus.conv_valid = 1'b0;
            check("tbl_pix_valid", bus.pix_valid, 1'b1);
            check("tbl_pix_data",  bus.pix_data,  vecs[i].exp);
            @(negedge clk);
        end

        do_reset();
        full_frame(8'h10, 1'b0);

        // Backpressure: fill FIFO, fifth result dropped and flags overflow.
        do_reset();
        bp_exp[0] = 8'h11; bp_exp[1] = 8'h22; bp_exp[2] = 8'h33; bp_exp[3] = 8'h44;
        for (int k = 0; k < 4; k++) begin
            bus.conv_valid = 1'b1;
            bus.conv_data  = {4'h0, bp_exp[k], 4'h0};
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, (k < 3) ? 1'b1 : 1'b0);
        end
        bus.conv_data = 16'h0AA0;
        @(negedge clk);
        bus.conv_valid = 1'b0;
        check("bp_overflow_set", bus.overflow, 1'b1);
        check("bp_head_stable",  bus.pix_data, bp_exp[0]);
        bus.pix_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_pix_valid", bus.pix_valid, 1'b1);
            check("bp_pix_data",  bus.pix_data,  bp_exp[k]);
            check("bp_ovf_sticky", bus.overflow, 1'b1);
            @(negedge clk);
        end
        check("bp_dropped", bus.pix_valid, 1'b0);
        check("bp_ovf_end", bus.overflow,  1'b1);

        // Simultaneous push/pop at occupancy 2 across pointer wrap.
        do_reset();
        for (int i = 0; i < 8; i++) pp[i] = 8'hA0 + 8'(i);
        for (int k = 0; k < 2; k++) begin
            bus.conv_valid = 1'b1;
            bus.conv_data  = {4'h0, pp[k], 4'h0};
            @(negedge clk);
        end
        bus.pix_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.conv_valid = 1'b1;
            bus.conv_data  = {4'h0, pp[i+2], 4'h0};
            check("pp_pix_data", bus.pix_data, pp[i]);
            check("pp_in_ready", bus.in_ready, 1'b1);
            @(negedge clk);
        end
        bus.conv_valid = 1'b0;
        for (int i = 6; i < 8; i++) begin
            check("pp_tail_valid", bus.pix_valid, 1'b1);
            check("pp_tail_data",  bus.pix_data,  pp[i]);
            @(negedge clk);
        end
        check("pp_empty", bus.pix_valid, 1'b0);

        // Reset mid-frame: five accepted, two still buffered.
        do_reset();
        bus.pix_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.conv_valid = 1'b1;
            bus.conv_data  = {4'h0, 8'h31 + 8'(k), 4'h0};
            @(negedge clk);
        end
        bus.conv_valid = 1'b0;
        @(negedge clk);
        bus.pix_ready = 1'b0;
        for (int k = 3; k < 5; k++) begin
            bus.conv_valid = 1'b1;
            bus.conv_data  = {4'h0, 8'h31 + 8'(k), 4'h0};
            @(negedge clk);
        end
        bus.conv_valid = 1'b0;
        check("mr_buffered", bus.pix_valid, 1'b1);
        check("mr_head",     bus.pix_data,  8'h34);
        fd0 = fd_count;
        do_reset();
        repeat (2) @(negedge clk);
        check("mr_no_frame_done", fd_count - fd0, 0);
        check("mr_empty_after",   bus.pix_valid, 1'b0);
        full_frame(8'h40, 1'b0);

        // DRAIN gating: conv_valid held through DRAIN.
        do_reset();
        full_frame(8'h60, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
